onehot_pulse_decoder: RTL

//  Sequential 3-to-8 decoder; the receiving end of the priority-encoder index path.

---
 rtl/onehot_pulse_decoder_pkg.sv | 27 ++
 rtl/onehot_pulse_decoder_if.sv | 11 +
 rtl/onehot_pulse_decoder_hold_cnt.sv | 32 +++
 rtl/onehot_pulse_decoder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/onehot_pulse_decoder_pkg.sv
// Shared definitions for the one-hot pulse decoder: FSM state encoding and
// the ceiling-log2 helper used to size the hold/gap counter.
package dec_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/onehot_pulse_decoder_if.sv
// Index handshake between an encoded-index source and the one-hot pulse decoder.
interface onehot_pulse_decoder_if #(
    parameter int IDX_W = 3
);
    logic             in_valid;
    logic [IDX_W-1:0] in_idx;
    logic             in_ready;

    modport master (output in_valid, output in_idx, input in_ready);
    modport slave  (input in_valid, input in_idx, output in_ready);
endinterface

// File: rtl/onehot_pulse_decoder_hold_cnt.sv
// Loadable down-counter that stops at zero; times the DRIVE and GAP phases.
module dec_hold_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load takes priority over counting; the count saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != {W{1'b0}})) begin
            cnt_q <= cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Sequential index-to-one-hot decoder producing a HOLD-cycle strobe then GAP idle cycles.
// Build option DEC_ERR_EN: adds the err port and rejects out-of-range indices.
module onehot_pulse_decoder
    import dec_pkg::*;
#(
    parameter int IDX_W = 3,
    parameter int N_OUT = 8,
    parameter int HOLD  = 4,
    parameter int GAP   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    onehot_pulse_decoder_if.slave  bus,
    output logic [N_OUT-1:0]       y_onehot,
    output logic                   busy,
`ifdef DEC_ERR_EN
    output logic                   err,
`endif
    output logic                   done
);

    localparam int CNT_W = clog2(max2(HOLD, GAP) + 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP > 0) ? (GAP - 1) : 0);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_OUT-1:0] y_q, y_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept_s, reject_s;
    logic             cnt_load_s, cnt_en_s, cnt_zero_s;
    logic [CNT_W-1:0] cnt_val_s, cnt_s;

    function automatic logic [N_OUT-1:0] decode(input logic [IDX_W-1:0] idx);
        logic [N_OUT-1:0] d;
        for (int i = 0; i < N_OUT; i++) begin
            d[i] = (int'(idx) == i);
        end
        return d;
    endfunction

    assign bus.in_ready = en & (state_q == ST_IDLE);
    assign accept_s     = bus.in_valid & bus.in_ready;

`ifdef DEC_ERR_EN
    logic err_q, err_d;
    logic in_range_s;
    assign in_range_s = (int'(bus.in_idx) < N_OUT);
    assign reject_s   = accept_s & ~in_range_s;
    assign err        = err_q;
`else
    assign reject_s   = 1'b0;
`endif

    dec_hold_cnt #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load_s),
        .en_i       (cnt_en_s),
        .load_val_i (cnt_val_s),
        .cnt_o      (cnt_s),
        .zero_o     (cnt_zero_s)
    );

    // Next-state logic; done is registered one cycle early so it lands on the last DRIVE cycle.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        y_d        = y_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cnt_load_s = 1'b0;
        cnt_en_s   = 1'b0;
        cnt_val_s  = HOLD_LD;
`ifdef DEC_ERR_EN
        err_d      = 1'b0;
`endif
        if (!en) begin
            state_d = ST_IDLE;
            y_d     = {N_OUT{1'b0}};
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (reject_s) begin
`ifdef DEC_ERR_EN
                        err_d = 1'b1;
`endif
                        y_d = {N_OUT{1'b0}};
                    end else if (accept_s) begin
                        state_d    = ST_DRIVE;
                        idx_d      = bus.in_idx;
                        y_d        = decode(bus.in_idx);
                        busy_d     = 1'b1;
                        cnt_load_s = 1'b1;
                        done_d     = (HOLD == 1);
                    end else begin
                        y_d    = {N_OUT{1'b0}};
                        busy_d = 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (!cnt_zero_s) begin
                        cnt_en_s = 1'b1;
                        y_d      = decode(idx_q);
                        done_d   = (cnt_s == {{(CNT_W-1){1'b0}}, 1'b1});
                    end else if (GAP > 0) begin
                        state_d    = ST_GAP;
                        y_d        = {N_OUT{1'b0}};
                        busy_d     = 1'b1;
                        cnt_load_s = 1'b1;
                        cnt_val_s  = GAP_LD;
                    end else begin
                        state_d = ST_IDLE;
                        y_d     = {N_OUT{1'b0}};
                        busy_d  = 1'b0;
                    end
                end
                ST_GAP: begin
                    if (cnt_zero_s) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_en_s = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    y_d     = {N_OUT{1'b0}};
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State, latched index and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= {IDX_W{1'b0}};
            y_q     <= {N_OUT{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef DEC_ERR_EN
    // Single-cycle rejection pulse for an out-of-range index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    assign y_onehot = y_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
